wb_trace_buffer: RTL and testbench
==================================

# wb_trace_buffer

Parametrised write-back trace recorder for the rv32IRJCore pipeline. It samples the WB-stage register write port (enable, address, data) every cycle and stores qualifying writes with a cycle timestamp in a DEPTH-entry buffer. The buffer supports stop-on-full or circular-overwrite mode and an optional address trigger. A valid/ready drain port reads the entries back. It sits beside the core, fed by the existing WB debug signals, and replaces per-cycle monitor printing with a bounded, synthesizable capture.

## Interface
- DATA_W, 32: width of write-back data.
- RADDR_W, 5: register address width.
- DEPTH, 16: number of entries; must be a power of two and ≥ 2.
- TS_W, 16: timestamp width.

- clk_i_core  in  1  sole clock; all state updates on the rising edge.
- reset_i_core  in  1  synchronous, active-high reset.
- wb_wrtEn_i  in  1  WB write enable.
- wb_wrtAddr_i  in  RADDR_W  WB destination register.
- wb_wrtData_i  in  DATA_W  WB write data.
- arm_i  in  1  single-cycle pulse that clears the buffer and starts a capture.
- stop_i  in  1  single-cycle pulse that forces DONE.
- cfg_wrap_i  in  1  1 = overwrite oldest entry when full; 0 = stop when full.
- cfg_trigEn_i  in  1  1 = wait for the trigger before capturing.
- cfg_trigAddr_i  in  RADDR_W  trigger register address.
- rd_valid_o  out  1  head entry available.
- rd_ready_i  in  1  consumer accepts the head entry.
- rd_addr_o  out  RADDR_W  head entry register address.
- rd_data_o  out  DATA_W  head entry data.
- rd_ts_o  out  TS_W  head entry timestamp.
- count_o  out  log2(DEPTH)+1  number of stored entries.
- overflow_o  out  1  sticky; at least one qualifying write was lost or overwritten.
- state_o  out  2  0 IDLE, 1 WAIT_TRIG, 2 CAPTURE, 3 DONE.

## Operation
- A write is **qualifying** when wb_wrtEn_i=1 and wb_wrtAddr_i≠0. Writes to x0 are never recorded.
- **State transitions:**
  - IDLE → arm_i → WAIT_TRIG if cfg_trigEn_i=1, else CAPTURE.
  - WAIT_TRIG → on a qualifying write with wb_wrtAddr_i == cfg_trigAddr_i → CAPTURE. The trigger write itself is stored.
  - CAPTURE, stop mode → DONE on the edge where count reaches DEPTH.
  - Any non-IDLE state → stop_i → DONE.
  - DONE stays in DONE until the next arm_i.
- **Arm:** clears the pointers, count, overflow flag and timestamp counter, then applies its transition. arm_i has priority over stop_i, push and pop in the same cycle. arm_i in any state (including mid-capture) restarts the capture.
- **Stop:** takes effect on the same edge; a write in that cycle is not stored.
- **Push:** only in CAPTURE, or on the WAIT_TRIG trigger edge. Stores {addr, data, ts} at the write pointer.
- **Pop:** occurs when rd_valid_o && rd_ready_i, in any state including DONE.
- **Full buffer, stop mode:** the push is impossible because the state is already DONE. A qualifying write in DONE reached via full sets overflow_o. A write in DONE reached via stop_i does not.
- **Full buffer, wrap mode, push without pop:** overwrite the oldest entry, advance the read pointer, leave count at DEPTH, set overflow_o.
- **Full buffer, wrap mode, push with pop:** the normal pop plus push; no overflow.
- **Empty buffer, push and pop in the same cycle:** no pop occurs (rd_valid_o=0); the push completes.
- **Pointers:** log2(DEPTH) bits, wrapping modulo DEPTH.
- **count:**
  - +1 on push only.
  - −1 on pop only.
  - Unchanged on push+pop, and on an overwrite.
- **Timestamp:** TS_W-bit counter, zeroed by arm_i, increments every cycle while the state is not IDLE. It wraps modulo 2^TS_W with no flag.
- **Read port:** first-word fall-through. rd_valid_o = (count≠0). rd_* present the entry at the read pointer combinationally from storage.

## Timing
- **Reset values:** state IDLE, count 0, overflow_o 0, rd_valid_o 0, rd_addr_o/rd_data_o/rd_ts_o 0, pointers 0, timestamp 0. Storage contents are don't-care but must not reach the rd_* outputs while empty; the outputs are forced to 0 when count=0.
- **Capture latency:** a qualifying write sampled at edge N appears on rd_* with rd_valid_o=1 after edge N, and count_o updates on the same edge.
- **Timestamp recorded:** the counter value before edge N. The first cycle after arm records ts=0.
- **Handshake:** rd_* are stable while rd_valid_o=1 && rd_ready_i=0, except under a wrap-mode overwrite, which is allowed to advance the head.
- **Throughput:** one push and one pop per cycle.

## Test plan
- **Stop mode, DEPTH=4:** reset, arm (cfg_wrap=0, trigEn=0), then writes x1=0xA, x0=0xB, x2=0xC, x3=0xD, x4=0xE, x5=0xF on consecutive cycles → x0 skipped; count=4, state DONE after the x4 write; x5 sets overflow_o=1; drain yields (1,0xA,ts0), (2,0xC,ts2), (3,0xD,ts3), (4,0xE,ts4).
- **Wrap mode, DEPTH=4:** six qualifying writes x1..x6 with rd_ready=0 → count=4, overflow_o=1; drain order is x3, x4, x5, x6.
- **Trigger:** trigEn=1, trigAddr=5; writes x3, x5, x6 → x3 not stored; state goes 1→2 at the x5 edge; drain yields x5 then x6.
- **Simultaneous push/pop when full (wrap mode):** rd_ready=1 held with a write every cycle → count stays 4 and overflow_o stays 0.
- **Arm mid-capture:** 3 entries stored, then arm_i together with a write → count=0, ts restarts at 0, the concurrent write is not stored, overflow cleared.
- **Reset mid-operation:** assert reset_i_core in CAPTURE with count=2 → on the next edge all outputs return to their reset values and state_o=0.

Source files
------------

// File: rtl/wb_trace_buffer.sv
// wb_trace_buffer: captures qualifying WB register writes with timestamps into a
// DEPTH-entry buffer (stop-on-full or wrap), with optional address trigger and FWFT drain.
module wb_trace_buffer #(
  parameter int DATA_W  = 32,
  parameter int RADDR_W = 5,
  parameter int DEPTH   = 16,
  parameter int TS_W    = 16
) (
  input  logic                       clk_i_core,
  input  logic                       reset_i_core,
  input  logic                       wb_wrtEn_i,
  input  logic [RADDR_W-1:0]         wb_wrtAddr_i,
  input  logic [DATA_W-1:0]          wb_wrtData_i,
  input  logic                       arm_i,
  input  logic                       stop_i,
  input  logic                       cfg_wrap_i,
  input  logic                       cfg_trigEn_i,
  input  logic [RADDR_W-1:0]         cfg_trigAddr_i,
  output logic                       rd_valid_o,
  input  logic                       rd_ready_i,
  output logic [RADDR_W-1:0]         rd_addr_o,
  output logic [DATA_W-1:0]          rd_data_o,
  output logic [TS_W-1:0]            rd_ts_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       overflow_o,
  output logic [1:0]                 state_o
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);
  typedef enum logic [1:0] {IDLE, WAIT_TRIG, CAPTURE, DONE} state_t;
  state_t r_state, w_state_n;
  logic [PW-1:0] r_wr_ptr, r_rd_ptr;
  logic [PW:0] r_count, w_count_n;
  logic [TS_W-1:0] r_ts;
  logic r_ovf, r_full_done, w_full_done_n;
  logic [RADDR_W-1:0] r_addr_mem [DEPTH];
  logic [DATA_W-1:0] r_data_mem [DEPTH];
  logic [TS_W-1:0] r_ts_mem [DEPTH];
  logic w_qual, w_trig, w_full, w_push, w_pop, w_ovr, w_store, w_lost, w_adv;
  assign w_qual  = wb_wrtEn_i && (wb_wrtAddr_i != '0);
  assign w_trig  = (r_state == WAIT_TRIG) && w_qual && (wb_wrtAddr_i == cfg_trigAddr_i);
  assign w_full  = r_count == FULL;
  assign w_push  = !arm_i && !stop_i && w_qual && ((r_state == CAPTURE) || w_trig);
  assign w_pop   = !arm_i && rd_valid_o && rd_ready_i;
  assign w_ovr   = w_push && w_full && !w_pop;
  assign w_store = w_push && (!w_ovr || cfg_wrap_i);
  // Only a DONE entered because the buffer filled counts later writes as lost.
  assign w_lost  = !arm_i && !stop_i && (r_state == DONE) && r_full_done && w_qual;
  assign w_adv   = w_pop || (w_store && w_ovr);
  assign w_count_n = (w_store && !w_pop && !w_full) ? r_count + (PW+1)'(1) :
                     (w_pop && !w_store) ? r_count - (PW+1)'(1) : r_count;
  always_comb begin
    w_state_n = r_state;
    w_full_done_n = r_full_done;
    if (arm_i) begin
      w_state_n = cfg_trigEn_i ? WAIT_TRIG : CAPTURE;
      w_full_done_n = 1'b0;
    end else if (stop_i && r_state != IDLE) begin
      w_state_n = DONE;
      w_full_done_n = 1'b0;
    end else if (w_trig) begin
      w_state_n = CAPTURE;
    end else if (r_state == CAPTURE && !cfg_wrap_i && w_count_n == FULL) begin
      w_state_n = DONE;
      w_full_done_n = 1'b1;
    end
  end
  always_ff @(posedge clk_i_core) begin
    if (reset_i_core) begin
      r_state <= IDLE;
      r_full_done <= 1'b0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count <= '0;
      r_ts <= '0;
      r_ovf <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_full_done <= w_full_done_n;
      if (arm_i) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count <= '0;
        r_ts <= '0;
        r_ovf <= 1'b0;
      end else begin
        r_count <= w_count_n;
        if (w_store) r_wr_ptr <= r_wr_ptr + PW'(1);
        if (w_adv) r_rd_ptr <= r_rd_ptr + PW'(1);
        if (r_state != IDLE) r_ts <= r_ts + TS_W'(1);
        if (w_ovr || w_lost) r_ovf <= 1'b1;
      end
    end
  end
  always_ff @(posedge clk_i_core) begin
    if (w_store) begin
      r_addr_mem[r_wr_ptr] <= wb_wrtAddr_i;
      r_data_mem[r_wr_ptr] <= wb_wrtData_i;
      r_ts_mem[r_wr_ptr] <= r_ts;
    end
  end
  assign rd_valid_o = r_count != '0;
  assign rd_addr_o  = rd_valid_o ? r_addr_mem[r_rd_ptr] : '0;
  assign rd_data_o  = rd_valid_o ? r_data_mem[r_rd_ptr] : '0;
  assign rd_ts_o    = rd_valid_o ? r_ts_mem[r_rd_ptr] : '0;
  assign count_o    = r_count;
  assign overflow_o = r_ovf;
  assign state_o    = r_state;
endmodule

// File: tb/tb_wb_trace_buffer.sv
// tb_wb_trace_buffer: directed and random stimulus against a queue-level trace model;
// drained entries are checked by a scoreboard monitor on each accepted handshake.
module tb_wb_trace_buffer;
  localparam int DEPTH = 4;
  typedef struct packed {logic [4:0] a; logic [31:0] d; logic [15:0] t;} ent_t;
  logic clk = 1'b0, rst = 1'b0, en = 1'b0, arm = 1'b0, stop = 1'b0, wrap = 1'b0;
  logic trig_en = 1'b0, ready = 1'b0;
  logic [4:0] addr = '0, trig_addr = '0;
  logic [31:0] data = '0;
  logic rd_valid, ovf;
  logic [4:0] rd_addr;
  logic [31:0] rd_data;
  logic [15:0] rd_ts;
  logic [2:0] count;
  logic [1:0] state;
  ent_t mq[$], sb[$];
  int ms = 0;
  logic [15:0] m_ts = '0;
  bit m_ovf = 0, m_fd = 0;
  int n_chk = 0, n_err = 0;
  wb_trace_buffer #(.DATA_W(32), .RADDR_W(5), .DEPTH(DEPTH), .TS_W(16)) dut (
    .clk_i_core(clk), .reset_i_core(rst), .wb_wrtEn_i(en), .wb_wrtAddr_i(addr),
    .wb_wrtData_i(data), .arm_i(arm), .stop_i(stop), .cfg_wrap_i(wrap),
    .cfg_trigEn_i(trig_en), .cfg_trigAddr_i(trig_addr), .rd_valid_o(rd_valid),
    .rd_ready_i(ready), .rd_addr_o(rd_addr), .rd_data_o(rd_data), .rd_ts_o(rd_ts),
    .count_o(count), .overflow_o(ovf), .state_o(state));
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  // Scoreboard monitor: every accepted head entry must match the next expected one.
  always @(negedge clk) begin
    if (!rst && !arm && rd_valid && ready) begin
      if (sb.size() == 0) chk("drain_unexpected", 1, 0);
      else chk("drain", {rd_addr, rd_data, rd_ts}, sb.pop_front());
    end
  end
  task automatic model_step();
    ent_t e;
    bit qual, push;
    int old;
    old = ms;
    if (arm) begin
      mq.delete(); m_ovf = 0; m_ts = '0; m_fd = 0; ms = trig_en ? 1 : 2;
      return;
    end
    if (mq.size() != 0 && ready) sb.push_back(mq.pop_front());
    qual = en && addr != 0;
    if (ms != 0 && stop) begin
      ms = 3; m_fd = 0;
    end else begin
      push = qual && (ms == 2 || (ms == 1 && addr == trig_addr));
      if (push) begin
        if (ms == 1) ms = 2;
        e = {addr, data, m_ts};
        if (mq.size() == DEPTH) begin
          m_ovf = 1;
          if (wrap) begin mq.delete(0); mq.push_back(e); end
        end else mq.push_back(e);
      end
      if (ms == 3 && m_fd && qual) m_ovf = 1;
      if (ms == 2 && !wrap && mq.size() == DEPTH) begin ms = 3; m_fd = 1; end
    end
    if (old != 0) m_ts++;
  endtask
  task automatic check_status();
    chk("count", count, mq.size());
    chk("state", state, ms);
    chk("overflow", ovf, m_ovf);
    chk("valid", rd_valid, mq.size() != 0);
    if (mq.size() != 0) chk("head", {rd_addr, rd_data, rd_ts}, mq[0]);
    else chk("head_zero", {rd_addr, rd_data, rd_ts}, 0);
  endtask
  task automatic cyc();
    model_step();
    @(posedge clk); #1;
    check_status();
  endtask
  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    en = 1'b1; addr = a; data = d;
    cyc();
    en = 1'b0;
  endtask
  task automatic do_arm(input logic w, input logic te, input logic [4:0] ta);
    wrap = w; trig_en = te; trig_addr = ta; arm = 1'b1;
    cyc();
    arm = 1'b0;
  endtask
  task automatic drain();
    ready = 1'b1; en = 1'b0;
    for (int i = 0; i < 2 * DEPTH + 2 && mq.size() != 0; i++) cyc();
    ready = 1'b0;
    chk("drained", sb.size(), 0);
  endtask
  task automatic do_reset();
    rst = 1'b1; en = 1'b0; arm = 1'b0; stop = 1'b0; ready = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    ms = 0; mq.delete(); sb.delete(); m_ts = '0; m_ovf = 0; m_fd = 0;
    chk("rst_all", {state, count, ovf, rd_valid, rd_addr, rd_data, rd_ts}, 0);
  endtask
  initial begin
    do_reset();
    // stop-on-full
    do_arm(1'b0, 1'b0, 5'd0);
    wr(5'd1, 32'hA);
    chk("first_ts", rd_ts, 0);
    wr(5'd0, 32'hB); wr(5'd2, 32'hC); wr(5'd3, 32'hD); wr(5'd4, 32'hE);
    chk("sm_count", count, 4);
    chk("sm_done", state, 3);
    chk("sm_ovf_before", ovf, 0);
    wr(5'd5, 32'hF);
    chk("sm_ovf", ovf, 1);
    drain();
    // wrap with overwrite
    do_arm(1'b1, 1'b0, 5'd0);
    for (int i = 1; i <= 6; i++) wr(5'(i), 32'h100 + i);
    chk("wr_count", count, 4);
    chk("wr_ovf", ovf, 1);
    chk("wr_head", rd_addr, 3);
    drain();
    // trigger
    do_arm(1'b0, 1'b1, 5'd5);
    chk("tr_wait", state, 1);
    wr(5'd3, 32'h33);
    chk("tr_skip", count, 0);
    wr(5'd5, 32'h55);
    chk("tr_cap", state, 2);
    wr(5'd6, 32'h66);
    drain();
    // full with simultaneous push and pop
    do_arm(1'b1, 1'b0, 5'd0);
    for (int i = 1; i <= 4; i++) wr(5'(i), 32'h200 + i);
    ready = 1'b1;
    for (int i = 0; i < 8; i++) wr(5'(1 + i % 7), $urandom);
    chk("pp_count", count, 4);
    chk("pp_ovf", ovf, 0);
    drain();
    // arm mid-capture after an overflow
    do_arm(1'b1, 1'b0, 5'd0);
    for (int i = 1; i <= 6; i++) wr(5'(i), 32'h300 + i);
    en = 1'b1; addr = 5'd9; data = 32'hDEAD;
    do_arm(1'b0, 1'b0, 5'd0);
    en = 1'b0;
    chk("am_count", count, 0);
    chk("am_ovf", ovf, 0);
    wr(5'd7, 32'h77);
    chk("am_ts", rd_ts, 0);
    drain();
    // reset mid-capture
    do_arm(1'b0, 1'b0, 5'd0);
    wr(5'd1, 32'h1); wr(5'd2, 32'h2);
    chk("pre_rst_count", count, 2);
    do_reset();
    // random traffic
    for (int i = 0; i < 800; i++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 3) begin
        wrap = $urandom_range(0, 1); trig_en = $urandom_range(0, 1);
        trig_addr = 5'($urandom_range(1, 7)); arm = 1'b1;
      end
      stop = (r >= 3 && r < 5);
      en = ($urandom_range(0, 9) < 7);
      addr = 5'($urandom_range(0, 7));
      data = $urandom;
      ready = $urandom_range(0, 1);
      cyc();
      arm = 1'b0; stop = 1'b0;
    end
    drain();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
